// File: rtl/decimate_var_if.sv
// Stream and configuration bundle for decimate_var.
// master = producer/consumer side, slave = the decimator.
interface decimate_var_if #(
    parameter int unsigned W    = 32,
    parameter int unsigned MMAX = 16,
    parameter int unsigned C    = 1,
    parameter int unsigned FW   = $clog2(MMAX + 1),
    parameter int unsigned OW   = W + $clog2(MMAX),
    parameter int unsigned CW   = (C > 1) ? $clog2(C) : 1
);
    logic          cfg_stb;
    logic [FW-1:0] cfg_factor;
    logic          cfg_mode;
    logic [W-1:0]  s_dat;
    logic          s_stb;
    logic          s_ack;
    logic [OW-1:0] m_dat;
    logic [CW-1:0] m_chn;
    logic          m_stb;
    logic          m_ack;

    modport master (
        output cfg_stb, cfg_factor, cfg_mode, s_dat, s_stb, m_ack,
        input  s_ack, m_dat, m_chn, m_stb
    );

    modport slave (
        input  cfg_stb, cfg_factor, cfg_mode, s_dat, s_stb, m_ack,
        output s_ack, m_dat, m_chn, m_stb
    );
endinterface

// File: rtl/decimate_var.sv
// Multi-channel stream decimator with runtime factor (pick-last or window sum).
// DECIMATE_VAR_SUM_EN builds sum mode and the per-channel accumulators.
module decimate_var #(
    parameter int unsigned W    = 32,
    parameter int unsigned M    = 4,
    parameter int unsigned MMAX = 16,
    parameter int unsigned C    = 1,
    localparam int unsigned FW  = $clog2(MMAX + 1),
    localparam int unsigned OW  = W + $clog2(MMAX),
    localparam int unsigned CW  = (C > 1) ? $clog2(C) : 1
) (
    input  logic          clk,
    input  logic          rst,
    decimate_var_if.slave bus
);

    function automatic logic [FW-1:0] clamp_factor(input logic [FW-1:0] f);
        if (f == '0) return FW'(1);
        if (f > FW'(MMAX)) return FW'(MMAX);
        return f;
    endfunction

    logic [CW-1:0] chan_q;
    logic [FW-1:0] phase_q;
    logic [FW-1:0] factor_q;
    logic [FW-1:0] sh_factor_q;
    logic [FW-1:0] sh_factor_d;
    logic          m_stb_q;
    logic [OW-1:0] m_dat_q;
    logic [CW-1:0] m_chn_q;

    logic          s_ack;
    logic          accept;
    logic          chan_last;
    logic          last_phase;
    logic          frame_end;
    logic          idle;
    logic [OW-1:0] out_dat;

`ifdef DECIMATE_VAR_SUM_EN
    logic          mode_q;
    logic          sh_mode_q;
    logic          sh_mode_d;
    logic [OW-1:0] acc_q [C];
    logic [OW-1:0] sum_w;
`else
    logic          unused_cfg_mode;
    assign unused_cfg_mode = bus.cfg_mode;
`endif

    assign s_ack     = !m_stb_q || bus.m_ack;
    assign bus.s_ack = s_ack;
    assign bus.m_stb = m_stb_q;
    assign bus.m_dat = m_dat_q;
    assign bus.m_chn = m_chn_q;

    always_comb begin
        accept      = bus.s_stb && s_ack;
        chan_last   = (chan_q == CW'(C - 1));
        last_phase  = (phase_q == factor_q - FW'(1));
        frame_end   = accept && last_phase && chan_last;
        idle        = !accept && (chan_q == '0) && (phase_q == '0);
        // Forwarding the shadow lets a write coincident with a boundary take effect there.
        sh_factor_d = bus.cfg_stb ? clamp_factor(bus.cfg_factor) : sh_factor_q;
`ifdef DECIMATE_VAR_SUM_EN
        sh_mode_d   = bus.cfg_stb ? bus.cfg_mode : sh_mode_q;
        sum_w       = ((phase_q == '0) ? '0 : acc_q[chan_q]) + OW'(bus.s_dat);
        out_dat     = mode_q ? sum_w : OW'(bus.s_dat);
`else
        out_dat     = OW'(bus.s_dat);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q      <= '0;
            phase_q     <= '0;
            factor_q    <= FW'(M);
            sh_factor_q <= FW'(M);
            m_stb_q     <= 1'b0;
            m_dat_q     <= '0;
            m_chn_q     <= '0;
`ifdef DECIMATE_VAR_SUM_EN
            mode_q      <= 1'b0;
            sh_mode_q   <= 1'b0;
            for (int unsigned i = 0; i < C; i++) acc_q[i] <= '0;
`endif
        end else begin
            sh_factor_q <= sh_factor_d;
`ifdef DECIMATE_VAR_SUM_EN
            sh_mode_q   <= sh_mode_d;
            if (frame_end || idle) mode_q <= sh_mode_d;
            if (accept && mode_q) acc_q[chan_q] <= sum_w;
`endif
            if (frame_end || idle) factor_q <= sh_factor_d;

            if (accept) begin
                chan_q <= chan_last ? '0 : chan_q + CW'(1);
                if (chan_last) phase_q <= last_phase ? '0 : phase_q + FW'(1);
            end

            if (accept && last_phase) begin
                m_stb_q <= 1'b1;
                m_dat_q <= out_dat;
                m_chn_q <= chan_q;
            end else if (bus.m_ack) begin
                m_stb_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decimate_var.sv
// Self-checking bench for decimate_var: directed steps plus random traffic against a window-list model.
module tb_decimate_var;
    localparam int unsigned W    = 32;
    localparam int unsigned MMAX = 8;
    localparam int unsigned C    = 2;
    localparam int unsigned M    = 4;
    localparam int unsigned FW   = $clog2(MMAX + 1);
    localparam int unsigned OW   = W + $clog2(MMAX);
    localparam int unsigned CW   = (C > 1) ? $clog2(C) : 1;
`ifdef DECIMATE_VAR_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decimate_var_if #(.W(W), .MMAX(MMAX), .C(C)) bus ();
    decimate_var #(.W(W), .M(M), .MMAX(MMAX), .C(C)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [CW-1:0] chn;
        logic [OW-1:0] dat;
    } out_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_ack = 1'b0;

    // Reference model: list of samples in the current window, active/shadow config.
    out_t          exp_q[$];
    out_t          rx_log[$];
    logic [W-1:0]  win[$];
    int unsigned   act_f = M, sh_f = M;
    bit            act_m = 1'b0, sh_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned clampf(input int unsigned f);
        if (f == 0) return 1;
        if (f > MMAX) return MMAX;
        return f;
    endfunction

    always @(negedge clk) begin
        bit            pend;
        bit            acc;
        int unsigned   k;
        logic [OW-1:0] sum;
        out_t          e;
        out_t          got;
        if (rst) begin
            win.delete();
            exp_q.delete();
            act_f = M; sh_f = M; act_m = 1'b0; sh_m = 1'b0;
        end else begin
            pend = (exp_q.size() != 0);
            acc  = bus.s_stb && (!pend || bus.m_ack);
            chk("m_stb", bus.m_stb, pend);
            chk("s_ack", bus.s_ack, !pend || bus.m_ack);
            if (pend && bus.m_ack) begin
                e = exp_q.pop_front();
                got.chn = bus.m_chn;
                got.dat = bus.m_dat;
                rx_log.push_back(got);
                chk("m_chn", bus.m_chn, e.chn);
                chk("m_dat", bus.m_dat, e.dat);
            end
            if (bus.cfg_stb) begin
                sh_f = clampf(bus.cfg_factor);
                sh_m = SUM_EN ? bus.cfg_mode : 1'b0;
            end
            if (acc) begin
                win.push_back(bus.s_dat);
                k = win.size() - 1;
                if (k / C == act_f - 1) begin
                    e.chn = CW'(k % C);
                    if (act_m) begin
                        sum = '0;
                        for (int unsigned j = k % C; j <= k; j += C) sum += OW'(win[j]);
                        e.dat = sum;
                    end else begin
                        e.dat = OW'(bus.s_dat);
                    end
                    exp_q.push_back(e);
                end
                if (win.size() == act_f * C) begin
                    win.delete();
                    act_f = sh_f; act_m = sh_m;
                end
            end else if (win.size() == 0) begin
                act_f = sh_f; act_m = sh_m;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.s_stb = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [W-1:0] d);
        int unsigned guard = 0;
        bit a;
        bus.s_stb = 1'b1;
        bus.s_dat = d;
        forever begin
            if (rand_ack) bus.m_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            a = bus.s_ack;
            tick();
            if (a) break;
            guard++;
            if (guard > 100) break;
        end
        if (guard > 100) chk("send_timeout", guard, 0);
        bus.s_stb = 1'b0;
    endtask

    task automatic cfg(input int unsigned f, input bit m);
        bus.cfg_stb    = 1'b1;
        bus.cfg_factor = FW'(f);
        bus.cfg_mode   = m;
        tick();
        bus.cfg_stb = 1'b0;
        idle(2);
    endtask

    task automatic chk_out(input string tag, input int idx, input int unsigned ch, input logic [OW-1:0] d);
        if (idx < rx_log.size()) begin
            chk({tag, "_chn"}, rx_log[idx].chn, ch);
            chk({tag, "_dat"}, rx_log[idx].dat, d);
        end else begin
            chk({tag, "_missing"}, rx_log.size(), idx + 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_stb = 1'b0; bus.cfg_factor = '0; bus.cfg_mode = 1'b0;
        bus.s_dat = '0; bus.s_stb = 1'b0; bus.m_ack = 1'b1;
        tick(); tick();
        chk("rst_m_stb", bus.m_stb, 0);
        chk("rst_m_dat", bus.m_dat, 0);
        chk("rst_m_chn", bus.m_chn, 0);
        chk("rst_s_ack", bus.s_ack, 1);
        rst = 1'b0;
        tick();

        // Pick mode with reset configuration (factor 4).
        rx_log.delete();
        for (int i = 0; i < 16; i++) send(W'(i));
        idle(3);
        chk("pick_cnt", rx_log.size(), 4);
        chk_out("pick0", 0, 0, 6);
        chk_out("pick1", 1, 1, 7);
        chk_out("pick2", 2, 0, 14);
        chk_out("pick3", 3, 1, 15);

        // Sum mode, factor 3.
        cfg(3, 1'b1);
        rx_log.delete();
        for (int i = 1; i <= 6; i++) begin
            send(W'(i));
            send(W'(10 * i));
        end
        idle(3);
        chk("sum_cnt", rx_log.size(), 4);
        chk_out("sum0", 0, 0, SUM_EN ? 6 : 3);
        chk_out("sum1", 1, 1, SUM_EN ? 60 : 30);
        chk_out("sum2", 2, 0, SUM_EN ? 15 : 6);
        chk_out("sum3", 3, 1, SUM_EN ? 150 : 60);

        // Backpressure: ch0 output stalls, ch1 final sample must wait.
        rx_log.delete();
        bus.m_ack = 1'b0;
        send(7); send(70); send(8); send(80); send(9);
        bus.s_stb = 1'b1;
        bus.s_dat = 90;
        repeat (5) begin
            @(negedge clk);
            chk("bp_s_ack", bus.s_ack, 0);
            chk("bp_m_stb", bus.m_stb, 1);
            chk("bp_m_dat", bus.m_dat, SUM_EN ? 24 : 9);
            chk("bp_m_chn", bus.m_chn, 0);
            tick();
        end
        bus.m_ack = 1'b1;
        send(90);
        idle(3);
        chk("bp_cnt", rx_log.size(), 2);
        chk_out("bp0", 0, 0, SUM_EN ? 24 : 9);
        chk_out("bp1", 1, 1, SUM_EN ? 240 : 90);

        // Random data with random m_ack, 11 whole windows of 6 samples.
        rx_log.delete();
        rand_ack = 1'b1;
        for (int i = 0; i < 66; i++) send($urandom);
        rand_ack = 1'b0;
        bus.m_ack = 1'b1;
        idle(4);
        chk("rand_cnt", rx_log.size(), 22);

        // Reconfig mid-window: 4 -> 2 after one frame.
        cfg(4, 1'b0);
        rx_log.delete();
        send(100); send(101);
        bus.cfg_stb = 1'b1; bus.cfg_factor = 2; bus.cfg_mode = 1'b0;
        tick();
        bus.cfg_stb = 1'b0;
        idle(2);
        for (int i = 2; i < 16; i++) send(W'(100 + i));
        idle(3);
        chk("rcfg_cnt", rx_log.size(), 6);
        chk_out("rcfg0", 0, 0, 106);
        chk_out("rcfg1", 1, 1, 107);
        chk_out("rcfg2", 2, 0, 110);
        chk_out("rcfg3", 3, 1, 111);
        chk_out("rcfg4", 4, 0, 114);
        chk_out("rcfg5", 5, 1, 115);

        // cfg_factor 0 behaves as 1.
        cfg(0, 1'b0);
        rx_log.delete();
        for (int i = 0; i < 4; i++) send(W'(200 + i));
        idle(3);
        chk("f0_cnt", rx_log.size(), 4);
        chk_out("f0_0", 0, 0, 200);
        chk_out("f0_3", 3, 1, 203);

        // cfg_factor 15 clamps to 8.
        cfg(15, 1'b0);
        rx_log.delete();
        for (int i = 0; i < 16; i++) send(W'(300 + i));
        idle(3);
        chk("f15_cnt", rx_log.size(), 2);
        chk_out("f15_0", 0, 0, 314);
        chk_out("f15_1", 1, 1, 315);

        // Full-scale sum, factor 8.
        cfg(8, 1'b1);
        rx_log.delete();
        for (int i = 0; i < 16; i++) send('1);
        idle(3);
        chk("ovf_cnt", rx_log.size(), 2);
        chk_out("ovf0", 0, 0, SUM_EN ? 35'h7FFFFFFF8 : 35'hFFFFFFFF);
        chk_out("ovf1", 1, 1, SUM_EN ? 35'h7FFFFFFF8 : 35'hFFFFFFFF);

        // Reset after 3 of 4 frames; only post-reset data may be emitted.
        cfg(4, 1'b0);
        rx_log.delete();
        for (int i = 0; i < 6; i++) send(W'(500 + i));
        rst = 1'b1;
        tick();
        chk("rstw_m_stb0", bus.m_stb, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstw_m_stb1", bus.m_stb, 0);
        for (int i = 0; i < 8; i++) send(W'(600 + i));
        idle(3);
        chk("rstw_cnt", rx_log.size(), 2);
        chk_out("rstw0", 0, 0, 606);
        chk_out("rstw1", 1, 1, 607);

        chk("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
